inst_data_ram: RTL and testbench
================================

Name: inst_data_ram

Overview:
- Byte-addressable, little-endian unified memory for the RV core.
- Has one synchronous data write port, one combinational data read port and one combinational instruction-fetch read port.
- The data port supports byte, halfword and word accesses selected by an access-size code.
- The bench drives the ports through an interface bundle named ram_if, which carries write_en, read_en, data_in, data_out, inst_out, data_addr and inst_addr.

Parameters:
- ADDR_MSB, 13, highest byte-address bit used.
  - Word index = addr[ADDR_MSB:2].
  - Depth = 2^(ADDR_MSB-1) 32-bit words; default is 4096 words (16 KiB).
  - Must be at least 11.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_en  input  2  data write size: 00 none, 01 byte, 10 halfword, 11 word.
- read_en  input  2  data read size: 00 none, 01 byte, 10 halfword, 11 word.
- data_addr  input  32  byte address for data reads and writes.
- data_in  input  32  write data; the payload is in the low bits (byte in [7:0], halfword in [15:0]).
- data_out  output  32  data read result, zero-extended.
- inst_addr  input  32  byte address for instruction fetch.
- inst_out  output  32  instruction word at inst_addr.

Behaviour:
- Storage is an array mem of 2^(ADDR_MSB-1) 32-bit words, indexed by addr[ADDR_MSB:2].
  - Address bits above ADDR_MSB are ignored (the memory aliases).
  - Byte lane k (k = addr[1:0]) is mem[idx][8k+7:8k] (little-endian).
- Reset:
  - While rst=1, every mem word is cleared to 0 asynchronously and writes are blocked.
  - data_out=0 and inst_out=0 while in reset.
  - After release, memory reads 0 until it is written.
- Write, on posedge clk when rst=0:
  - 11: mem[idx] <= data_in; addr[1:0] is ignored.
  - 10: the halfword selected by addr[1] gets data_in[15:0]; addr[0] is ignored; the other halfword is unchanged.
  - 01: byte lane addr[1:0] gets data_in[7:0]; the other three bytes are unchanged.
  - 00: no change.
  - The write result is visible in mem after the clock edge (1-cycle write latency).
- Data read is combinational, with no clock latency:
  - 11: data_out = mem[idx].
  - 10: data_out = {16'b0, halfword selected by addr[1]}.
  - 01: data_out = {24'b0, byte lane addr[1:0]}.
  - 00: data_out = 0.
- Instruction read is combinational and always active:
  - inst_out = mem[inst_addr[ADDR_MSB:2]].
  - inst_addr[1:0] is ignored.
- read_en and write_en are independent. If both are active on the same address, the read returns the pre-edge contents until the edge, then the new contents (write-first only after the edge).
- The instruction and data ports may target the same word at the same time; both return the same contents.
- There is no misalignment trap: low address bits are dropped as described above.

Test Plan:
- Write sequence at 0xf0, with rst=0 and each step checked one cycle later:
  - word 0x00ff00ff -> mem = 0x00ff00ff.
  - write_en=00 with data 0x00ff00 -> mem unchanged.
  - halfword 0x122200 -> 0x00ff2200.
  - byte 0xff11 -> 0x00ff2211.
  - byte at 0xf2 with data 0x999933 -> 0x00332211.
  - halfword at 0xf2 with data 0x991111 -> 0x11112211.
- Word writes: 0x1234 at 0xf00 and 0xababa at 0xab0 -> the respective words match and the word at 0xf0 is unchanged.
- Data reads from 0xf0 (0x11112211):
  - word -> 0x11112211.
  - read_en=00 -> 0.
  - halfword -> 0x2211.
  - byte -> 0x11.
  - byte at 0xf1 -> 0x22.
  - halfword at 0xf2 -> 0x1111.
  - All results are valid within 2 ns of the input change, with no clock edge.
- Instruction fetch, in parallel with the reads above:
  - inst_addr 0xf0 -> 0x11112211.
  - inst_addr 0xf00 -> 0x1234.
  - inst_addr 0xab0 -> 0xababa.
- Reset:
  - Assert rst mid-test, asynchronously between edges -> data_out and inst_out = 0 immediately.
  - A word write attempted during reset is ignored.
  - After release, reading 0xf0 returns 0.
- Aliasing: a word write to 0xf0 + 2^(ADDR_MSB+1) -> readable at 0xf0.

Source files
------------

// File: rtl/inst_data_ram_if.sv
// Signal bundle for the unified instruction/data memory. Used by the bench
// to carry the non-clock port signals of inst_data_ram.
interface ram_if;
    logic [1:0]  write_en;
    logic [1:0]  read_en;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [31:0] inst_out;
    logic [31:0] data_addr;
    logic [31:0] inst_addr;
endinterface

// File: rtl/inst_data_ram.sv
// Byte-addressable, little-endian unified memory for the RV core.
// One synchronous data write port (byte/halfword/word), one combinational
// data read port and one combinational instruction-fetch port. Every word
// is cleared asynchronously by rst, so storage is built from registers
// rather than block RAM.
module inst_data_ram #(
    parameter int ADDR_MSB = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  write_en,
    input  logic [1:0]  read_en,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_out
);

    localparam int IDX_W = ADDR_MSB - 1;
    localparam int DEPTH = 2 ** IDX_W;

    // Word view of storage, one element per register word below.
    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] data_idx;
    logic [IDX_W-1:0] inst_idx;
    logic [31:0]      data_word;
    logic [3:0]       byte_we;
    logic [31:0]      lane_data;
    logic [31:0]      word_next;
    logic             write_any;

    // High address bits alias and the fetch port ignores the byte offset.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_MSB+1], inst_addr[1:0],
                                data_addr[31:ADDR_MSB+1]};

    assign data_idx  = data_addr[ADDR_MSB:2];
    assign inst_idx  = inst_addr[ADDR_MSB:2];
    assign data_word = mem[data_idx];
    assign write_any = |byte_we;

    // Decode the access size and low address bits into per-lane write
    // enables and replicate the payload so every lane sees its byte.
    always_comb begin
        byte_we   = 4'b0000;
        lane_data = data_in;
        case (write_en)
            2'b11: begin
                byte_we   = 4'b1111;
                lane_data = data_in;
            end
            2'b10: begin
                byte_we   = data_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {data_in[15:0], data_in[15:0]};
            end
            2'b01: begin
                byte_we   = 4'b0001 << data_addr[1:0];
                lane_data = {4{data_in[7:0]}};
            end
            default: begin
                byte_we   = 4'b0000;
                lane_data = data_in;
            end
        endcase
    end

    // Merge new lanes with the untouched bytes of the addressed word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word_next[8*gi +: 8] = byte_we[gi] ? lane_data[8*gi +: 8]
                                                  : data_word[8*gi +: 8];
    end

    // One register per memory word, cleared asynchronously by rst.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [31:0] word_reg;
        logic        word_we;

        assign word_we = write_any && (data_idx == IDX_W'(gi));

        // Capture the merged word on a write to this index.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                word_reg <= 32'h0;
            end else if (word_we) begin
                word_reg <= word_next;
            end
        end

        assign mem[gi] = word_reg;
    end

    // Combinational data read, zero-extended to the access size.
    always_comb begin
        data_out = 32'h0;
        if (!rst) begin
            case (read_en)
                2'b11: data_out = data_word;
                2'b10: data_out = {16'h0, data_addr[1] ? data_word[31:16]
                                                       : data_word[15:0]};
                2'b01: begin
                    case (data_addr[1:0])
                        2'b00:   data_out = {24'h0, data_word[7:0]};
                        2'b01:   data_out = {24'h0, data_word[15:8]};
                        2'b10:   data_out = {24'h0, data_word[23:16]};
                        default: data_out = {24'h0, data_word[31:24]};
                    endcase
                end
                default: data_out = 32'h0;
            endcase
        end
    end

    // Combinational instruction fetch, always active outside reset.
    always_comb begin
        inst_out = 32'h0;
        if (!rst) begin
            inst_out = mem[inst_idx];
        end
    end

endmodule

// File: tb/tb_inst_data_ram.sv
// Directed, table-driven bench for inst_data_ram. Each vector drives the
// ports at a falling edge, checks the combinational outputs 2 ns later
// (before the rising edge, so reads see pre-write contents) and then lets
// the rising edge commit any write.
module tb_inst_data_ram;

    typedef struct {
        logic [1:0]  we;
        logic [1:0]  re;
        logic [31:0] daddr;
        logic [31:0] din;
        logic [31:0] iaddr;
        logic [31:0] exp_data;
        logic [31:0] exp_inst;
    } vec_t;

    logic clk;
    logic rst;
    ram_if bus ();

    int n_applied;
    int n_bad;

    vec_t vecs[$];

    inst_data_ram #(.ADDR_MSB(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (bus.write_en),
        .read_en   (bus.read_en),
        .data_addr (bus.data_addr),
        .data_in   (bus.data_in),
        .data_out  (bus.data_out),
        .inst_addr (bus.inst_addr),
        .inst_out  (bus.inst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, actual, expected);
        end else begin
            $display("ok   %s: %08h", name, actual);
        end
    endtask

    task automatic add(input logic [1:0] we, input logic [1:0] re,
                       input logic [31:0] daddr, input logic [31:0] din,
                       input logic [31:0] iaddr, input logic [31:0] exp_data,
                       input logic [31:0] exp_inst);
        vec_t v;
        v.we = we; v.re = re; v.daddr = daddr; v.din = din;
        v.iaddr = iaddr; v.exp_data = exp_data; v.exp_inst = exp_inst;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] we, input logic [1:0] re,
                         input logic [31:0] daddr, input logic [31:0] din,
                         input logic [31:0] iaddr);
        bus.write_en  = we;
        bus.read_en   = re;
        bus.data_addr = daddr;
        bus.data_in   = din;
        bus.inst_addr = iaddr;
    endtask

    initial begin
        n_applied = 0;
        n_bad     = 0;

        //   we     re     daddr         din           iaddr         exp_data      exp_inst
        // Write sequence at 0xf0; each read shows the pre-edge contents.
        add(2'b11, 2'b11, 32'h0000_00f0, 32'h00ff_00ff, 32'h0000_00f0, 32'h0000_0000, 32'h0000_0000);
        add(2'b00, 2'b11, 32'h0000_00f0, 32'h0000_ff00, 32'h0000_00f0, 32'h00ff_00ff, 32'h00ff_00ff);
        add(2'b10, 2'b11, 32'h0000_00f0, 32'h0012_2200, 32'h0000_00f0, 32'h00ff_00ff, 32'h00ff_00ff);
        add(2'b01, 2'b11, 32'h0000_00f0, 32'h0000_ff11, 32'h0000_00f0, 32'h00ff_2200, 32'h00ff_2200);
        add(2'b01, 2'b11, 32'h0000_00f2, 32'h0099_9933, 32'h0000_00f0, 32'h00ff_2211, 32'h00ff_2211);
        add(2'b10, 2'b11, 32'h0000_00f2, 32'h0099_1111, 32'h0000_00f0, 32'h0033_2211, 32'h0033_2211);
        // Word writes elsewhere; 0xf0 stays intact.
        add(2'b11, 2'b11, 32'h0000_0f00, 32'h0000_1234, 32'h0000_00f0, 32'h0000_0000, 32'h1111_2211);
        add(2'b11, 2'b11, 32'h0000_0ab0, 32'h000a_baba, 32'h0000_0f00, 32'h0000_0000, 32'h0000_1234);
        // Data reads with parallel instruction fetch.
        add(2'b00, 2'b11, 32'h0000_00f0, 32'h0000_0000, 32'h0000_0ab0, 32'h1111_2211, 32'h000a_baba);
        add(2'b00, 2'b00, 32'h0000_00f0, 32'h0000_0000, 32'h0000_00f0, 32'h0000_0000, 32'h1111_2211);
        add(2'b00, 2'b10, 32'h0000_00f0, 32'h0000_0000, 32'h0000_0f00, 32'h0000_2211, 32'h0000_1234);
        add(2'b00, 2'b01, 32'h0000_00f0, 32'h0000_0000, 32'h0000_0ab0, 32'h0000_0011, 32'h000a_baba);
        add(2'b00, 2'b01, 32'h0000_00f1, 32'h0000_0000, 32'h0000_00f2, 32'h0000_0022, 32'h1111_2211);
        add(2'b00, 2'b10, 32'h0000_00f2, 32'h0000_0000, 32'h0000_0f03, 32'h0000_1111, 32'h0000_1234);
        add(2'b00, 2'b10, 32'h0000_00f3, 32'h0000_0000, 32'h0000_00f1, 32'h0000_1111, 32'h1111_2211);
        add(2'b00, 2'b11, 32'h0000_00f3, 32'h0000_0000, 32'h0000_00f0, 32'h1111_2211, 32'h1111_2211);
        // Unaligned word write drops addr[1:0]; halfword drops addr[0].
        add(2'b11, 2'b11, 32'h0000_0f03, 32'h5566_7788, 32'h0000_0f02, 32'h0000_1234, 32'h0000_1234);
        add(2'b00, 2'b11, 32'h0000_0f00, 32'h0000_0000, 32'h0000_0f01, 32'h5566_7788, 32'h5566_7788);
        add(2'b10, 2'b10, 32'h0000_0f01, 32'h0000_aaaa, 32'h0000_0f00, 32'h0000_7788, 32'h5566_7788);
        add(2'b01, 2'b01, 32'h0000_0f03, 32'h0000_00cc, 32'h0000_0f00, 32'h0000_0055, 32'h5566_aaaa);
        add(2'b00, 2'b11, 32'h0000_0f00, 32'h0000_0000, 32'h0000_0f00, 32'hcc66_aaaa, 32'hcc66_aaaa);
        // Aliasing: 0xf0 + 2^14 maps onto 0xf0.
        add(2'b11, 2'b11, 32'h0000_40f0, 32'hdead_beef, 32'h0000_40f0, 32'h1111_2211, 32'h1111_2211);
        add(2'b00, 2'b11, 32'h0000_00f0, 32'h0000_0000, 32'h0000_00f0, 32'hdead_beef, 32'hdead_beef);

        // Reset from time 0 with a clean rising edge on rst.
        rst = 1'b0;
        drive(2'b00, 2'b11, 32'h0000_00f0, 32'h0, 32'h0000_00f0);
        #1 rst = 1'b1;
        #2;
        check("reset_data_out", bus.data_out, 32'h0);
        check("reset_inst_out", bus.inst_out, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].re, vecs[i].daddr, vecs[i].din, vecs[i].iaddr);
            #2;
            check($sformatf("vec%0d_data", i), bus.data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_inst", i), bus.inst_out, vecs[i].exp_inst);
        end

        // Asynchronous reset asserted between edges clears outputs at once.
        @(negedge clk);
        drive(2'b00, 2'b11, 32'h0000_00f0, 32'h0, 32'h0000_0f00);
        #2;
        check("pre_rst_data", bus.data_out, 32'hdead_beef);
        check("pre_rst_inst", bus.inst_out, 32'hcc66_aaaa);
        #1 rst = 1'b1;
        #1;
        check("async_rst_data", bus.data_out, 32'h0);
        check("async_rst_inst", bus.inst_out, 32'h0);
        // Word write attempted while reset is held must be ignored.
        drive(2'b11, 2'b11, 32'h0000_00f0, 32'h1234_5678, 32'h0000_00f0);
        @(posedge clk);
        @(negedge clk);
        drive(2'b00, 2'b11, 32'h0000_00f0, 32'h0, 32'h0000_0f00);
        rst = 1'b0;
        #2;
        check("post_rst_data_f0", bus.data_out, 32'h0);
        check("post_rst_inst_f00", bus.inst_out, 32'h0);
        bus.inst_addr = 32'h0000_0ab0;
        #1;
        check("post_rst_inst_ab0", bus.inst_out, 32'h0);

        // Writes work again after release.
        @(negedge clk);
        drive(2'b11, 2'b11, 32'h0000_00f0, 32'h0bad_f00d, 32'h0000_00f0);
        @(negedge clk);
        drive(2'b00, 2'b11, 32'h0000_00f0, 32'h0, 32'h0000_00f0);
        #2;
        check("post_rst_write_data", bus.data_out, 32'h0bad_f00d);
        check("post_rst_write_inst", bus.inst_out, 32'h0bad_f00d);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_bad);
        $finish;
    end

endmodule
